fifo_entrada: RTL and testbench

Input buffer for the second-stage arbiter: a first-word-fall-through (FWFT) FIFO that stores 12-bit words from the upstream source. It presents the head word and an empty flag to the arbiter, which pops it. Almost-full and almost-empty flags provide back-pressure upstream. Four instances of the same block, one per output lane, also serve as the downstream FIFOs fed by the arbiter's `push[3:0]`, supplying its `almost_fullFIFO[3:0]`.

---
 rtl/fifo_entrada_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 39 +++
 rtl/fifo_entrada.sv | 94 +++++++++
 tb/tb_fifo_entrada.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_entrada_pkg.sv
// Shared widths, reset level and transfer-acceptance decode for the input/lane FIFOs.
// Arbiter-side code imports the same package so widths stay in lockstep.
package fifo_entrada_pkg;

    localparam int   DATA_WIDTH_DEF = 12;
    localparam int   DEPTH_DEF      = 8;
    localparam int   PTR_W_DEF      = 3;
    localparam logic RST_ACTIVE     = 1'b0;

    typedef struct packed {
        logic push_ok;
        logic pop_ok;
        logic fault;
    } xfer_t;

    // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
    function automatic xfer_t decode_xfer(input logic push, input logic pop,
                                          input logic is_empty, input logic is_full);
        xfer_t x;
        x.pop_ok  = pop & ~is_empty;
        x.push_ok = push & (~is_full | x.pop_ok);
        x.fault   = (push & ~x.push_ok) | (pop & ~x.pop_ok);
        return x;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on rdata after the edge; reset clears every entry.
module fifo_mem
    import fifo_entrada_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int PTR_W      = PTR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_entrada.sv
// FWFT FIFO: head word on data_out with zero read latency, pop acts on the next edge.
// Push at full is dropped (unless paired with a pop); pop at empty is ignored; both set sticky error.
module fifo_entrada
    import fifo_entrada_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int PTR_W      = PTR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [PTR_W:0]        umbral_af,
    input  logic [PTR_W:0]        umbral_ae,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  emptyFIFO,
    output logic                  fullFIFO,
    output logic                  almost_fullFIFO,
    output logic                  almost_emptyFIFO,
    output logic                  error,
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  error_q, error_d;
    logic [PTR_W:0]        af_q, af_d;
    logic [PTR_W:0]        ae_q, ae_d;
    logic [DATA_WIDTH-1:0] head_dat;
    xfer_t                 xfer;

    always_comb begin
        xfer     = decode_xfer(push, pop, count_q == '0, count_q == FULL_CNT);
        wr_ptr_d = wr_ptr_q + PTR_W'(xfer.push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(xfer.pop_ok);
        count_d  = count_q;
        case ({xfer.push_ok, xfer.pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        error_d = error_q | xfer.fault;
        // Thresholds track their inputs only while reset is held, then freeze.
        af_d = (reset == RST_ACTIVE) ? umbral_af : af_q;
        ae_d = (reset == RST_ACTIVE) ? umbral_ae : ae_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        af_q <= af_d;
        ae_q <= ae_d;
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk  (clk),
        .rst_n(reset),
        .we   (xfer.push_ok),
        .waddr(wr_ptr_q),
        .wdata(data_in),
        .raddr(rd_ptr_q),
        .rdata(head_dat)
    );

    assign data_out         = (count_q != '0) ? head_dat : '0;
    assign emptyFIFO        = (count_q == '0);
    assign fullFIFO         = (count_q == FULL_CNT);
    assign almost_fullFIFO  = (count_q >= af_q);
    assign almost_emptyFIFO = (count_q <= ae_q);
    assign error            = error_q;
    assign count            = count_q;

endmodule

// File: tb/tb_fifo_entrada.sv
// Randomized and directed stimulus against a queue-based reference model of the FIFO.
module tb_fifo_entrada;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [11:0] data_in;
    logic        pop;
    logic [3:0]  umbral_af;
    logic [3:0]  umbral_ae;
    logic [11:0] data_out;
    logic        emptyFIFO;
    logic        fullFIFO;
    logic        almost_fullFIFO;
    logic        almost_emptyFIFO;
    logic        error;
    logic [3:0]  count;

    int num_tests = 0;
    int num_fail  = 0;

    logic [11:0] m_q [$];
    logic        m_err;
    int          m_af;
    int          m_ae;

    always #5 clk = ~clk;

    fifo_entrada dut (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .data_in         (data_in),
        .pop             (pop),
        .umbral_af       (umbral_af),
        .umbral_ae       (umbral_ae),
        .data_out        (data_out),
        .emptyFIFO       (emptyFIFO),
        .fullFIFO        (fullFIFO),
        .almost_fullFIFO (almost_fullFIFO),
        .almost_emptyFIFO(almost_emptyFIFO),
        .error           (error),
        .count           (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_tests++;
        if (obs !== exp) begin
            num_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int          n;
        logic [11:0] head;
        n    = m_q.size();
        head = (n > 0) ? m_q[0] : 12'h000;
        chk({tag, ":count"},    32'(count),            32'(n));
        chk({tag, ":data_out"}, 32'(data_out),         32'(head));
        chk({tag, ":empty"},    32'(emptyFIFO),        32'(n == 0));
        chk({tag, ":full"},     32'(fullFIFO),         32'(n == 8));
        chk({tag, ":afull"},    32'(almost_fullFIFO),  32'(n >= m_af));
        chk({tag, ":aempty"},   32'(almost_emptyFIFO), 32'(n <= m_ae));
        chk({tag, ":error"},    32'(error),            32'(m_err));
    endtask

    // Reference behaviour of one accepted clock edge.
    task automatic model_step(input logic p, input logic [11:0] d, input logic q);
        logic pop_ok, push_ok;
        pop_ok  = q && (m_q.size() > 0);
        push_ok = p && ((m_q.size() < 8) || pop_ok);
        if ((p && !push_ok) || (q && !pop_ok)) m_err = 1'b1;
        if (pop_ok) void'(m_q.pop_front());
        if (push_ok) m_q.push_back(d);
    endtask

    task automatic cycle(input string tag, input logic p, input logic [11:0] d, input logic q);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        model_step(p, d, q);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_all(tag);
    endtask

    // Asserts reset away from any clock edge and checks outputs before the next edge.
    task automatic reset_pulse(input string tag);
        #2;
        reset = 1'b0;
        #1;
        m_q.delete();
        m_err = 1'b0;
        check_all({tag, ":async"});
        @(posedge clk);
        m_af = int'(umbral_af);
        m_ae = int'(umbral_ae);
        #1;
        check_all({tag, ":held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = 12'h000;
        umbral_af = 4'd6;
        umbral_ae = 4'd1;
        m_err     = 1'b0;
        repeat (2) @(posedge clk);
        m_af = 6;
        m_ae = 1;
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("idle");

        for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 12'(i), 1'b0);
        cycle("push_full", 1'b1, 12'hABC, 1'b0);
        for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 12'h000, 1'b1);

        for (int i = 1; i <= 8; i++) cycle("refill", 1'b1, 12'(i), 1'b0);
        cycle("full_pushpop", 1'b1, 12'h555, 1'b1);
        for (int i = 0; i < 8; i++) cycle("drain2", 1'b0, 12'h000, 1'b1);

        umbral_af = 4'd0;
        umbral_ae = 4'd8;
        reset_pulse("rst_thr");
        cycle("empty_pushpop", 1'b1, 12'h0F0, 1'b1);
        cycle("after_epp", 1'b0, 12'h000, 1'b0);

        umbral_af = 4'd5;
        umbral_ae = 4'd2;
        reset_pulse("rst_rand");
        for (int i = 0; i < 160; i++) begin
            logic p, q;
            p = ($urandom_range(0, 99) < 60);
            q = ($urandom_range(0, 99) < 45);
            cycle("rand", p, 12'($urandom), q);
            if (i == 20 || i == 90) begin
                umbral_af = 4'($urandom_range(0, 8));
                umbral_ae = 4'($urandom_range(0, 8));
                reset_pulse("rst_mid");
                // New inputs must not disturb the frozen thresholds.
                umbral_af = 4'($urandom_range(0, 8));
                umbral_ae = 4'($urandom_range(0, 8));
            end
        end

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
        $finish;
    end

endmodule
